// File: rtl/base_active_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : base_active_mc_pkg
// Brief    : Shared constants and types for the multi-channel stream tracker
// Revision : 1.0 - initial release
// ============================================================================
package base_active_mc_pkg;

  // Error codes reported on o_err_code
  localparam logic [1:0] c_err_bad_tag  = 2'd0;
  localparam logic [1:0] c_err_orphan   = 2'd1;
  localparam logic [1:0] c_err_dup_start = 2'd2;
  localparam logic [1:0] c_err_overflow = 2'd3;

  // Per-channel combinational events raised by an accepted beat
  typedef struct packed {
    logic done;    // stream ended on this beat
    logic orphan;  // beat on an idle channel without start (explicit mode)
    logic dup;     // start flag on an already open stream
    logic ovf;     // beat arrived while the counter was saturated
  } ch_evt_t;

endpackage
`default_nettype wire

// File: rtl/base_active_ch.sv
`default_nettype none
// ============================================================================
// Module   : base_active_ch
// Brief    : One channel of the stream tracker: active flag, beat counter
//            and the events a beat on this channel produces
// Revision : 1.0 - initial release
// ============================================================================
module base_active_ch
  import base_active_mc_pkg::*;
#(
  parameter int mode  = 0,
  parameter int beatw = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beat,     // accepted, in-range beat for this channel
  input  logic             s,
  input  logic             e,
  input  logic             clr,
  output logic             act_q,    // registered active flag
  output logic             act_nx,   // next-state active flag
  output ch_evt_t          evt,
  output logic [beatw-1:0] len       // final count when evt.done
);

  logic [beatw-1:0] w_cnt_q;
  logic [beatw-1:0] w_cnt_d;
  logic [beatw-1:0] w_next;
  logic             w_sat;
  logic             w_open_ok;

  // Next-state and event decode; a clear overrides everything on this channel
  always_comb begin
    act_nx    = act_q;
    w_cnt_d   = w_cnt_q;
    evt       = '0;
    len       = '0;
    w_sat     = &w_cnt_q;
    w_open_ok = (mode == 0) || s;
    w_next    = act_q ? (w_sat ? w_cnt_q : w_cnt_q + 1'b1) : beatw'(1);
    if (clr) begin
      act_nx  = 1'b0;
      w_cnt_d = '0;
    end else if (beat) begin
      if (!act_q && !w_open_ok) begin
        evt.orphan = 1'b1;
      end else begin
        evt.dup = act_q && (mode == 1) && s;
        evt.ovf = act_q && w_sat;
        if (e) begin
          act_nx   = 1'b0;
          w_cnt_d  = '0;
          evt.done = 1'b1;
          len      = w_next;
        end else begin
          act_nx  = 1'b1;
          w_cnt_d = w_next;
        end
      end
    end
  end

  base_vlat #(.w(1)) u_act (
    .clk(clk), .reset(reset), .en(1'b1), .d(act_nx), .q(act_q)
  );

  base_vlat #(.w(beatw)) u_cnt (
    .clk(clk), .reset(reset), .en(1'b1), .d(w_cnt_d), .q(w_cnt_q)
  );

endmodule
`default_nettype wire

// File: rtl/base_vlat.sv
`default_nettype none
// ============================================================================
// Module   : base_vlat
// Brief    : Generic enabled register with asynchronous active-high reset
// Revision : 1.0 - initial release
// ============================================================================
module base_vlat #(
  parameter int w = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [w-1:0] d,
  output logic [w-1:0] q
);

  // State register: clears to zero on reset, loads d when enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/base_active_mc.sv
`default_nettype none
// ============================================================================
// Module   : base_active_mc
// Brief    : Multi-channel stream activity tracker with per-channel beat
//            counting, end-of-stream reports and protocol error reports
// Revision : 1.0 - initial release
// ============================================================================
module base_active_mc
  import base_active_mc_pkg::*;
#(
  parameter int nch   = 4,
  parameter int tagw  = 2,
  parameter int beatw = 8,
  parameter int mode  = 0,
  parameter int del   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  input  logic             i_r,
  input  logic [tagw-1:0]  i_tag,
  input  logic             i_s,
  input  logic             i_e,
  input  logic [nch-1:0]   i_clr,
  output logic [nch-1:0]   o_act,
  output logic [tagw:0]    o_act_cnt,
  output logic             o_done_v,
  output logic [tagw-1:0]  o_done_tag,
  output logic [beatw-1:0] o_done_len,
  output logic             o_err_v,
  output logic [1:0]       o_err_code,
  output logic [tagw-1:0]  o_err_tag
);

  logic             w_acc;
  logic             w_bad;
  logic [31:0]      w_tag_ext;
  logic [nch-1:0]   w_beat;
  logic [nch-1:0]   w_act_q;
  logic [nch-1:0]   w_act_nx;
  ch_evt_t          w_evt [nch];
  logic [beatw-1:0] w_len [nch];

  ch_evt_t          w_any;
  logic [beatw-1:0] w_len_sel;
  logic             w_err_v_d;
  logic [1:0]       w_err_code_d;
  logic [tagw-1:0]  w_done_tag_d;
  logic [tagw-1:0]  w_err_tag_d;
  logic [beatw-1:0] w_done_len_d;

  assign w_acc     = i_v & i_r;
  assign w_tag_ext = 32'(i_tag);
  assign w_bad     = w_acc && (w_tag_ext >= 32'(nch));

  for (genvar k = 0; k < nch; k++) begin : g_ch
    assign w_beat[k] = w_acc && !w_bad && (w_tag_ext == 32'(k));

    base_active_ch #(.mode(mode), .beatw(beatw)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .beat   (w_beat[k]),
      .s      (i_s),
      .e      (i_e),
      .clr    (i_clr[k]),
      .act_q  (w_act_q[k]),
      .act_nx (w_act_nx[k]),
      .evt    (w_evt[k]),
      .len    (w_len[k])
    );
  end

  // Merge channel events; only the addressed channel can raise any of them
  always_comb begin
    w_any     = '0;
    w_len_sel = '0;
    for (int k = 0; k < nch; k++) begin
      w_any.done   = w_any.done   | w_evt[k].done;
      w_any.orphan = w_any.orphan | w_evt[k].orphan;
      w_any.dup    = w_any.dup    | w_evt[k].dup;
      w_any.ovf    = w_any.ovf    | w_evt[k].ovf;
      w_len_sel    = w_len_sel    | w_len[k];
    end
  end

  // Error priority: bad tag, orphan, duplicate start, overflow
  always_comb begin
    w_err_v_d    = 1'b1;
    w_err_code_d = c_err_bad_tag;
    if (w_bad) begin
      w_err_code_d = c_err_bad_tag;
    end else if (w_any.orphan) begin
      w_err_code_d = c_err_orphan;
    end else if (w_any.dup) begin
      w_err_code_d = c_err_dup_start;
    end else if (w_any.ovf) begin
      w_err_code_d = c_err_overflow;
    end else begin
      w_err_v_d = 1'b0;
    end
  end

  assign w_done_tag_d = w_any.done ? i_tag : '0;
  assign w_done_len_d = w_any.done ? w_len_sel : '0;
  assign w_err_tag_d  = w_err_v_d ? i_tag : '0;

  base_vlat #(.w(1))     u_done_v   (.clk(clk), .reset(reset), .en(1'b1), .d(w_any.done),   .q(o_done_v));
  base_vlat #(.w(tagw))  u_done_tag (.clk(clk), .reset(reset), .en(1'b1), .d(w_done_tag_d), .q(o_done_tag));
  base_vlat #(.w(beatw)) u_done_len (.clk(clk), .reset(reset), .en(1'b1), .d(w_done_len_d), .q(o_done_len));
  base_vlat #(.w(1))     u_err_v    (.clk(clk), .reset(reset), .en(1'b1), .d(w_err_v_d),    .q(o_err_v));
  base_vlat #(.w(2))     u_err_code (.clk(clk), .reset(reset), .en(1'b1), .d(w_err_code_d), .q(o_err_code));
  base_vlat #(.w(tagw))  u_err_tag  (.clk(clk), .reset(reset), .en(1'b1), .d(w_err_tag_d),  .q(o_err_tag));

  // Popcount of the registered flags
  always_comb begin
    o_act_cnt = '0;
    for (int k = 0; k < nch; k++) begin
      o_act_cnt = o_act_cnt + (tagw+1)'(w_act_q[k]);
    end
  end

  if (del == 1) begin : g_act_reg
    assign o_act = w_act_q;
  end else begin : g_act_nx
    assign o_act = w_act_nx & {nch{~reset}};
  end

endmodule
`default_nettype wire

// File: tb/tb_base_active_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_base_active_mc
// Brief    : Self-checking bench for base_active_mc, four configurations
//            driven from one vector table with a pulse scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module tb_base_active_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic       v [4];
  logic       r [4];
  logic [2:0] tag [4];
  logic       s [4];
  logic       e [4];
  logic [3:0] clr [4];

  logic [3:0] act [4];
  logic [3:0] acnt [4];
  logic       dv [4];
  logic [2:0] dtag [4];
  logic [7:0] dlen [4];
  logic       ev [4];
  logic [1:0] ecode [4];
  logic [2:0] etag [4];

  always #5 clk = ~clk;

  // Configurations: 0 implicit/registered, 1 explicit/next-state,
  // 2 implicit/registered with 2-bit counters, 3 implicit/next-state tagw=3
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int TW = (g == 3) ? 3 : 2;
    localparam int BW = (g == 2) ? 2 : 8;
    localparam int MD = (g == 1) ? 1 : 0;
    localparam int DL = (g == 1 || g == 3) ? 0 : 1;
    logic [3:0]    w_act;
    logic [TW:0]   w_ac;
    logic          w_dv, w_ev;
    logic [TW-1:0] w_dt, w_et;
    logic [BW-1:0] w_dl;
    logic [1:0]    w_ec;

    base_active_mc #(.nch(4), .tagw(TW), .beatw(BW), .mode(MD), .del(DL)) u_dut (
      .clk(clk), .reset(reset), .i_v(v[g]), .i_r(r[g]), .i_tag(tag[g][TW-1:0]),
      .i_s(s[g]), .i_e(e[g]), .i_clr(clr[g]), .o_act(w_act), .o_act_cnt(w_ac),
      .o_done_v(w_dv), .o_done_tag(w_dt), .o_done_len(w_dl), .o_err_v(w_ev),
      .o_err_code(w_ec), .o_err_tag(w_et)
    );

    assign act[g]   = w_act;
    assign acnt[g]  = 4'(w_ac);
    assign dv[g]    = w_dv;
    assign dtag[g]  = 3'(w_dt);
    assign dlen[g]  = 8'(w_dl);
    assign ev[g]    = w_ev;
    assign ecode[g] = w_ec;
    assign etag[g]  = 3'(w_et);
  end

  typedef struct {
    int         d;
    logic       v, r;
    logic [2:0] tag;
    logic       s, e;
    logic [3:0] clr;
    logic [3:0] xact;
    logic [3:0] xcnt;
    logic       xdv;
    logic [2:0] xdt;
    logic [7:0] xdl;
    logic       xev;
    logic [1:0] xec;
    logic [2:0] xet;
  } vec_t;

  typedef struct {
    int         idx;
    int         d;
    logic [3:0] xcnt;
    logic       xdv;
    logic [2:0] xdt;
    logic [7:0] xdl;
    logic       xev;
    logic [1:0] xec;
    logic [2:0] xet;
  } sb_t;

  vec_t vt[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(int d, logic vv, logic rr, logic [2:0] tg, logic ss, logic ee,
                              logic [3:0] cl, logic [3:0] xa, logic [3:0] xc, logic xdv,
                              logic [2:0] xdt, logic [7:0] xdl, logic xev, logic [1:0] xec,
                              logic [2:0] xet);
    vec_t t;
    t.d = d; t.v = vv; t.r = rr; t.tag = tg; t.s = ss; t.e = ee; t.clr = cl;
    t.xact = xa; t.xcnt = xc; t.xdv = xdv; t.xdt = xdt; t.xdl = xdl;
    t.xev = xev; t.xec = xec; t.xet = xet;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b0; r[i] = 1'b0; tag[i] = 3'd0; s[i] = 1'b0; e[i] = 1'b0; clr[i] = 4'd0;
    end
  endtask

  task automatic chk_quiet(input string nm, input int d);
    chk({nm, " act"}, 32'(act[d]), 32'd0);
    chk({nm, " act_cnt"}, 32'(acnt[d]), 32'd0);
    chk({nm, " done_v"}, 32'(dv[d]), 32'd0);
    chk({nm, " err_v"}, 32'(ev[d]), 32'd0);
  endtask

  initial begin
    sb_t x;
    reset = 1'b1;
    idle_all();

    // D0: implicit start, registered o_act
    vt.push_back(mk(0,1,1,3'd2,0,0,4'h0, 4'h0,4'd1, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(0,1,1,3'd2,0,0,4'h0, 4'h4,4'd1, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(0,1,1,3'd2,0,1,4'h0, 4'h4,4'd0, 1,3'd2,8'd3, 0,2'd0,3'd0));
    vt.push_back(mk(0,0,0,3'd0,0,0,4'h0, 4'h0,4'd0, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(0,1,0,3'd1,0,0,4'h0, 4'h0,4'd0, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(0,1,1,3'd3,0,1,4'h0, 4'h0,4'd0, 1,3'd3,8'd1, 0,2'd0,3'd0));
    vt.push_back(mk(0,1,1,3'd0,0,0,4'h0, 4'h0,4'd1, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(0,1,1,3'd0,0,1,4'h1, 4'h1,4'd0, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(0,0,0,3'd0,0,0,4'h0, 4'h0,4'd0, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(0,1,1,3'd1,0,0,4'h0, 4'h0,4'd1, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(0,0,0,3'd0,0,0,4'h2, 4'h2,4'd0, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(0,0,0,3'd0,0,0,4'h0, 4'h0,4'd0, 0,3'd0,8'd0, 0,2'd0,3'd0));
    // D1: explicit start, next-state o_act
    vt.push_back(mk(1,1,1,3'd1,0,0,4'h0, 4'h0,4'd0, 0,3'd0,8'd0, 1,2'd1,3'd1));
    vt.push_back(mk(1,1,1,3'd1,1,0,4'h0, 4'h2,4'd1, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(1,1,1,3'd1,1,0,4'h0, 4'h2,4'd1, 0,3'd0,8'd0, 1,2'd2,3'd1));
    vt.push_back(mk(1,1,1,3'd1,0,1,4'h0, 4'h0,4'd0, 1,3'd1,8'd3, 0,2'd0,3'd0));
    vt.push_back(mk(1,0,0,3'd0,0,0,4'h0, 4'h0,4'd0, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(1,1,1,3'd0,1,0,4'h0, 4'h1,4'd1, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(1,1,1,3'd0,0,0,4'h1, 4'h0,4'd0, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(1,1,1,3'd2,1,1,4'h0, 4'h0,4'd0, 1,3'd2,8'd1, 0,2'd0,3'd0));
    // D2: 2-bit counters saturate at 3
    vt.push_back(mk(2,1,1,3'd0,0,0,4'h0, 4'h0,4'd1, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(2,1,1,3'd0,0,0,4'h0, 4'h1,4'd1, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(2,1,1,3'd0,0,0,4'h0, 4'h1,4'd1, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(2,1,1,3'd0,0,0,4'h0, 4'h1,4'd1, 0,3'd0,8'd0, 1,2'd3,3'd0));
    vt.push_back(mk(2,1,1,3'd0,0,1,4'h0, 4'h1,4'd0, 1,3'd0,8'd3, 1,2'd3,3'd0));
    // D3: out-of-range tag, then three channels left open
    vt.push_back(mk(3,1,1,3'd5,0,0,4'h0, 4'h0,4'd0, 0,3'd0,8'd0, 1,2'd0,3'd5));
    vt.push_back(mk(3,1,1,3'd0,0,0,4'h0, 4'h1,4'd1, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(3,1,1,3'd1,0,0,4'h0, 4'h3,4'd2, 0,3'd0,8'd0, 0,2'd0,3'd0));
    vt.push_back(mk(3,1,1,3'd2,0,0,4'h0, 4'h7,4'd3, 0,3'd0,8'd0, 0,2'd0,3'd0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk_quiet($sformatf("reset d%0d", d), d);
      chk($sformatf("reset d%0d done_tag", d), 32'(dtag[d]), 32'd0);
      chk($sformatf("reset d%0d done_len", d), 32'(dlen[d]), 32'd0);
      chk($sformatf("reset d%0d err_code", d), 32'(ecode[d]), 32'd0);
      chk($sformatf("reset d%0d err_tag", d), 32'(etag[d]), 32'd0);
    end
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven vectors with pulse scoreboard
    for (int i = 0; i < vt.size(); i++) begin
      idle_all();
      v[vt[i].d] = vt[i].v; r[vt[i].d] = vt[i].r; tag[vt[i].d] = vt[i].tag;
      s[vt[i].d] = vt[i].s; e[vt[i].d] = vt[i].e; clr[vt[i].d] = vt[i].clr;
      #3;
      chk($sformatf("v%0d act", i), 32'(act[vt[i].d]), 32'(vt[i].xact));
      x.idx = i; x.d = vt[i].d; x.xcnt = vt[i].xcnt; x.xdv = vt[i].xdv; x.xdt = vt[i].xdt;
      x.xdl = vt[i].xdl; x.xev = vt[i].xev; x.xec = vt[i].xec; x.xet = vt[i].xet;
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk($sformatf("v%0d scoreboard empty", i), 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        chk($sformatf("v%0d act_cnt", x.idx), 32'(acnt[x.d]), 32'(x.xcnt));
        chk($sformatf("v%0d done_v", x.idx), 32'(dv[x.d]), 32'(x.xdv));
        chk($sformatf("v%0d err_v", x.idx), 32'(ev[x.d]), 32'(x.xev));
        if (x.xdv) begin
          chk($sformatf("v%0d done_tag", x.idx), 32'(dtag[x.d]), 32'(x.xdt));
          chk($sformatf("v%0d done_len", x.idx), 32'(dlen[x.d]), 32'(x.xdl));
        end
        if (x.xev) begin
          chk($sformatf("v%0d err_code", x.idx), 32'(ecode[x.d]), 32'(x.xec));
          chk($sformatf("v%0d err_tag", x.idx), 32'(etag[x.d]), 32'(x.xet));
        end
      end
    end

    // Mid-stream reset on D3 with three channels open and a beat pending
    idle_all();
    v[3] = 1'b1; r[3] = 1'b1; tag[3] = 3'd3;
    reset = 1'b1;
    #1;
    chk_quiet("midrst async", 3);
    @(posedge clk);
    #1;
    chk_quiet("midrst held", 3);
    idle_all();
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk_quiet("postrst", 3);

    // Fresh stream after reset opens normally
    v[3] = 1'b1; r[3] = 1'b1; tag[3] = 3'd0;
    #3;
    chk("postrst open act", 32'(act[3]), 32'h1);
    @(posedge clk);
    #1;
    chk("postrst open act_cnt", 32'(acnt[3]), 32'd1);
    chk("postrst open done_v", 32'(dv[3]), 32'd0);
    idle_all();
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
